// File: rtl/stream_chk_pkg.sv
// Shared types and constants for the stream pattern checker.
package stream_chk_pkg;

    // Packet-tracking states of the checker FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } state_e;

    // Bit positions inside err_flags.
    localparam int ERR_PAT   = 0;  // data word broke the +STEP sequence
    localparam int ERR_NOSOP = 1;  // beat arrived outside a packet without sop
    localparam int ERR_NOEOP = 2;  // new sop arrived before the previous eop
    localparam int ERR_LEN   = 3;  // packet too long, or empty used off the eop beat

    // Defaults matching what the ethernet test source emits.
    localparam int DEF_STEP      = 4;
    localparam int DEF_MAX_WORDS = 256;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    logic [W-1:0] r_value;

    // Count events, hold at full scale, clear on request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/stream_pattern_checker.sv
// Avalon-ST sink that throttles its input, checks sop/eop framing and the
// incrementing data pattern, and keeps sticky flags plus saturating stats.
module stream_pattern_checker
    import stream_chk_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int STEP      = DEF_STEP,
    parameter  int MAX_WORDS = DEF_MAX_WORDS,
    parameter  int CNT_W     = 16,
    localparam int EMPTY_W   = $clog2(WIDTH/8),
    localparam int LEN_W     = $clog2(MAX_WORDS) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   data,
    input  logic               valid,
    input  logic               sop,
    input  logic               eop,
    input  logic [EMPTY_W-1:0] empty,
    output logic               ready,
    input  logic [3:0]         thr_period,
    input  logic               clr,
    output logic [CNT_W-1:0]   pkt_ok_cnt,
    output logic [CNT_W-1:0]   pkt_err_cnt,
    output logic [LEN_W-1:0]   last_len,
    output logic [3:0]         err_flags,
    output logic               busy
);

    state_e             r_state, w_state_nxt;
    logic [3:0]         r_thr_cnt, w_thr_nxt;
    logic               r_ready;
    logic [WIDTH-1:0]   r_prev;
    logic [WIDTH-1:0]   w_expect;
    logic [LEN_W-1:0]   r_len, w_len_nxt, w_len_inc;
    logic [LEN_W-1:0]   r_last_len;
    logic               r_bad, w_bad_nxt;
    logic [3:0]         r_flags, w_flags_set;
    logic               w_acc, w_inc_ok, w_inc_err, w_upd_last;
    logic               w_empty_bad, w_mismatch, w_thr_off;

    assign w_acc       = valid & r_ready;
    assign w_thr_off   = (thr_period < 4'd2);
    assign w_expect    = r_prev + WIDTH'(STEP);
    assign w_mismatch  = (data != w_expect);
    assign w_empty_bad = (empty != '0) && !eop;
    assign w_len_inc   = (r_len > LEN_W'(MAX_WORDS)) ? r_len : r_len + LEN_W'(1);

    // Throttle counter wraps at thr_period-1; out-of-range values restart at 0.
    always_comb begin
        w_thr_nxt = r_thr_cnt + 4'd1;
        if (w_thr_off || (r_thr_cnt >= thr_period - 4'd1)) begin
            w_thr_nxt = 4'd0;
        end
    end

    // Registered ready: low for the one cycle per period where the counter hits its top.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_thr_cnt <= 4'd0;
            r_ready   <= 1'b0;
        end else begin
            r_thr_cnt <= w_thr_nxt;
            r_ready   <= w_thr_off || (w_thr_nxt != thr_period - 4'd1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, error detection and stat events for the accepted beat.
    always_comb begin
        w_state_nxt = r_state;
        w_flags_set = 4'b0000;
        w_inc_ok    = 1'b0;
        w_inc_err   = 1'b0;
        w_len_nxt   = r_len;
        w_bad_nxt   = r_bad;
        w_upd_last  = 1'b0;
        if (w_acc) begin
            if (sop) begin
                // A sop always starts a fresh packet; inside a packet it aborts the old one.
                if (r_state == IN_PKT) begin
                    w_flags_set[ERR_NOEOP] = 1'b1;
                    w_inc_err              = 1'b1;
                end
                w_len_nxt            = LEN_W'(1);
                w_bad_nxt            = w_empty_bad;
                w_flags_set[ERR_LEN] = w_empty_bad;
                if (eop) begin
                    w_upd_last  = 1'b1;
                    w_inc_ok    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = IN_PKT;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        w_flags_set[ERR_NOSOP] = 1'b1;
                    end
                    DROP: begin
                        if (eop) begin
                            w_state_nxt = IDLE;
                        end
                    end
                    IN_PKT: begin
                        w_len_nxt = w_len_inc;
                        if (w_len_inc > LEN_W'(MAX_WORDS)) begin
                            // Overlong packets are counted once, then the rest is discarded.
                            w_flags_set[ERR_LEN] = 1'b1;
                            w_inc_err            = 1'b1;
                            w_state_nxt          = eop ? IDLE : DROP;
                        end else begin
                            w_flags_set[ERR_PAT] = w_mismatch;
                            w_flags_set[ERR_LEN] = w_empty_bad;
                            w_bad_nxt            = r_bad | w_mismatch | w_empty_bad;
                            if (eop) begin
                                w_upd_last  = 1'b1;
                                w_inc_ok    = !w_bad_nxt;
                                w_inc_err   = w_bad_nxt;
                                w_state_nxt = IDLE;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                    end
                endcase
            end
        end
    end

    // Previous data word; only meaningful while a packet is open, so no reset.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_prev <= data;
        end
    end

    // Packet length, bad marker, last length and sticky flags; clr wins over updates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len      <= '0;
            r_bad      <= 1'b0;
            r_last_len <= '0;
            r_flags    <= 4'b0000;
        end else begin
            if (w_acc) begin
                r_len <= w_len_nxt;
                r_bad <= w_bad_nxt;
            end
            if (clr) begin
                r_last_len <= '0;
                r_flags    <= 4'b0000;
            end else begin
                if (w_upd_last) begin
                    r_last_len <= w_len_nxt;
                end
                r_flags <= r_flags | w_flags_set;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_ok_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_ok),
        .clr   (clr),
        .value (pkt_ok_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_err),
        .clr   (clr),
        .value (pkt_err_cnt)
    );

    assign ready     = r_ready;
    assign last_len  = r_last_len;
    assign err_flags = r_flags;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_stream_pattern_checker.sv
// Directed bench for stream_pattern_checker: two instances (MAX_WORDS 256 and 8)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_stream_pattern_checker;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic        valid, sop, eop, clr;
    logic [1:0]  empty;
    logic [3:0]  thr_period;

    logic        ready0, ready1;
    logic [15:0] ok0, err0, ok1, err1;
    logic [8:0]  last0;
    logic [3:0]  last1;
    logic [3:0]  flags0, flags1;
    logic        busy0, busy1;

    int total = 0;
    int bad   = 0;

    stream_pattern_checker #(.WIDTH(32), .STEP(4), .MAX_WORDS(256), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .sop(sop), .eop(eop),
        .empty(empty), .ready(ready0), .thr_period(thr_period), .clr(clr),
        .pkt_ok_cnt(ok0), .pkt_err_cnt(err0), .last_len(last0),
        .err_flags(flags0), .busy(busy0)
    );

    stream_pattern_checker #(.WIDTH(32), .STEP(4), .MAX_WORDS(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .sop(sop), .eop(eop),
        .empty(empty), .ready(ready1), .thr_period(thr_period), .clr(clr),
        .pkt_ok_cnt(ok1), .pkt_err_cnt(err1), .last_len(last1),
        .err_flags(flags1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Packet position: 0 = outside a packet, 1 = inside, 2 = discarding an overlong one.
    int          m_pos [2];
    int          m_len [2];
    int          m_ok  [2];
    int          m_err [2];
    int          m_last[2];
    logic [31:0] m_prev[2];
    bit          m_bad [2];
    logic [3:0]  m_flg [2];
    int          m_phase;
    bit          m_ready;
    logic [3:0]  s_set;
    bit          s_ok, s_err, s_lu;
    int          s_lv, s_mx;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_pos[k] = 0; m_len[k] = 0; m_ok[k] = 0; m_err[k] = 0;
                m_last[k] = 0; m_prev[k] = 32'd0; m_bad[k] = 0; m_flg[k] = 4'd0;
            end
            m_phase = 0;
            m_ready = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                s_mx = (k == 0) ? 256 : 8;
                s_set = 4'd0; s_ok = 0; s_err = 0; s_lu = 0; s_lv = 0;
                if (valid && m_ready) begin
                    if (sop) begin
                        if (m_pos[k] == 1) begin s_set[2] = 1'b1; s_err = 1; end
                        m_prev[k] = data;
                        m_len[k]  = 1;
                        m_bad[k]  = (empty != 2'd0) && !eop;
                        if (m_bad[k]) s_set[3] = 1'b1;
                        if (eop) begin s_lu = 1; s_lv = 1; s_ok = 1; m_pos[k] = 0; end
                        else m_pos[k] = 1;
                    end else if (m_pos[k] == 0) begin
                        s_set[1] = 1'b1;
                    end else if (m_pos[k] == 2) begin
                        if (eop) m_pos[k] = 0;
                    end else begin
                        m_len[k] = m_len[k] + 1;
                        if (m_len[k] > s_mx) begin
                            s_set[3] = 1'b1; s_err = 1;
                            m_pos[k] = eop ? 0 : 2;
                        end else begin
                            if (data != 32'(m_prev[k] + 32'd4)) begin s_set[0] = 1'b1; m_bad[k] = 1; end
                            if (empty != 2'd0 && !eop) begin s_set[3] = 1'b1; m_bad[k] = 1; end
                            m_prev[k] = data;
                            if (eop) begin
                                s_lu = 1; s_lv = m_len[k];
                                if (m_bad[k]) s_err = 1; else s_ok = 1;
                                m_pos[k] = 0;
                            end
                        end
                    end
                end
                if (clr) begin
                    m_ok[k] = 0; m_err[k] = 0; m_last[k] = 0; m_flg[k] = 4'd0;
                end else begin
                    m_flg[k] = m_flg[k] | s_set;
                    if (s_ok  && m_ok[k]  < 65535) m_ok[k]++;
                    if (s_err && m_err[k] < 65535) m_err[k]++;
                    if (s_lu) m_last[k] = s_lv;
                end
            end
            if (thr_period < 2) m_phase = 0;
            else m_phase = (m_phase + 1) % int'(thr_period);
            m_ready = (thr_period < 2) || (m_phase != int'(thr_period) - 1);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("ready0", 32'(ready0), 32'(m_ready));
        chk("ready1", 32'(ready1), 32'(m_ready));
        chk("ok0",    32'(ok0),    32'(m_ok[0]));
        chk("err0",   32'(err0),   32'(m_err[0]));
        chk("last0",  32'(last0),  32'(m_last[0]));
        chk("flags0", 32'(flags0), 32'(m_flg[0]));
        chk("busy0",  32'(busy0),  32'(m_pos[0] != 0));
        chk("ok1",    32'(ok1),    32'(m_ok[1]));
        chk("err1",   32'(err1),   32'(m_err[1]));
        chk("last1",  32'(last1),  32'(m_last[1]));
        chk("flags1", 32'(flags1), 32'(m_flg[1]));
        chk("busy1",  32'(busy1),  32'(m_pos[1] != 0));
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
        bit got;
        data = d; sop = s; eop = e; empty = emp; valid = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = ready0;
            @(posedge clk);
        end
        #1;
        valid = 1'b0; sop = 1'b0; eop = 1'b0; empty = 2'd0;
        if (!got) begin
            total++; bad++;
            $display("FAIL send_timeout: ready never high for beat %0h", d);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    int lows;

    initial begin
        rst = 1'b0; data = 32'd0; valid = 1'b0; sop = 1'b0; eop = 1'b0;
        empty = 2'd0; clr = 1'b0; thr_period = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready0), 32'd0);
        chk("rst_ok",    32'(ok0),    32'd0);
        chk("rst_busy",  32'(busy0),  32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_up", 32'(ready0), 32'd1);

        // Pattern wrap across 2^32.
        send(32'h0, 1, 0, 0); send(32'h4, 0, 0, 0); send(32'h8, 0, 0, 0); send(32'hC, 0, 1, 0);
        send(32'hFFFFFFF8, 1, 0, 0); send(32'hFFFFFFFC, 0, 0, 0); send(32'h0, 0, 1, 0);
        chk("wrap_ok",    32'(ok0),    32'd2);
        chk("wrap_len",   32'(last0),  32'd3);
        chk("wrap_flags", 32'(flags0), 32'd0);

        // Pattern error.
        pulse_clr();
        send(32'h10, 1, 0, 0); send(32'h14, 0, 0, 0); send(32'h19, 0, 0, 0); send(32'h1D, 0, 1, 0);
        chk("pat_flags", 32'(flags0), 32'h1);
        chk("pat_err",   32'(err0),   32'd1);
        chk("pat_ok",    32'(ok0),    32'd0);
        chk("pat_len",   32'(last0),  32'd4);

        // Framing: stray beat, aborted packet, empty misuse.
        pulse_clr();
        send(32'h55, 0, 0, 0);
        chk("nosop_flags", 32'(flags0), 32'h2);
        send(32'h100, 1, 0, 0); send(32'h104, 0, 0, 0);
        send(32'h200, 1, 0, 0); send(32'h204, 0, 1, 0);
        chk("noeop_flags", 32'(flags0), 32'h6);
        chk("noeop_err",   32'(err0),   32'd1);
        chk("noeop_ok",    32'(ok0),    32'd1);
        send(32'h300, 1, 0, 2'd1); send(32'h304, 0, 1, 0);
        chk("empty_flags", 32'(flags0), 32'hE);
        chk("empty_err",   32'(err0),   32'd2);

        // Overlength on the MAX_WORDS=8 instance; the 256 instance sees a good packet.
        pulse_clr();
        for (int i = 0; i < 12; i++) begin
            send(32'h1000 + 32'(4 * i), (i == 0), (i == 11), 2'd0);
            if (i == 8) begin
                chk("ovl_flag9", 32'(flags1), 32'h8);
                chk("ovl_err9",  32'(err1),   32'd1);
                chk("ovl_drop",  32'(busy1),  32'd1);
            end
        end
        chk("ovl_idle",  32'(busy1), 32'd0);
        chk("ovl_err",   32'(err1),  32'd1);
        chk("ovl_ok",    32'(ok1),   32'd0);
        chk("long_ok",   32'(ok0),   32'd1);
        chk("long_len",  32'(last0), 32'd12);

        // Backpressure, period 3.
        pulse_clr();
        thr_period = 4'd3;
        repeat (4) @(posedge clk);
        #1;
        data = 32'h77; sop = 1'b1; eop = 1'b1; valid = 1'b1;
        lows = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!ready0) lows++;
            @(posedge clk);
        end
        #1;
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
        chk("thr_lows", 32'(lows), 32'd10);
        chk("thr_ok20", 32'(ok0),  32'd20);
        pulse_clr();
        for (int i = 0; i < 10; i++) send(32'hABC0 + 32'(4 * i), (i == 0), (i == 9), 2'd0);
        chk("thr_ok",    32'(ok0),    32'd1);
        chk("thr_len",   32'(last0),  32'd10);
        chk("thr_flags", 32'(flags0), 32'd0);
        thr_period = 4'd0;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a packet.
        send(32'h40, 1, 0, 0); send(32'h44, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_ready", 32'(ready0), 32'd0);
        chk("arst_ok",    32'(ok0),    32'd0);
        chk("arst_busy",  32'(busy0),  32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send(32'h80, 1, 0, 0); send(32'h84, 0, 0, 0); send(32'h88, 0, 1, 0);
        chk("post_ok",  32'(ok0),   32'd1);
        chk("post_len", 32'(last0), 32'd3);
        chk("post_err", 32'(err0),  32'd0);

        // clr in the same cycle as a completing eop.
        clr = 1'b1;
        send(32'h90, 1, 1, 0);
        clr = 1'b0;
        chk("clr_ok",  32'(ok0),   32'd0);
        chk("clr_len", 32'(last0), 32'd0);
        send(32'h94, 1, 1, 0);
        chk("single_ok",  32'(ok0),   32'd1);
        chk("single_len", 32'(last0), 32'd1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
